// File: rtl/cv32e40s_xsecure_lfsr_pkg.sv
// Shared LFSR constants, FSM state type and step function for the xsecure blocks.
package cv32e40s_xsecure_lfsr_pkg;

  localparam logic [31:0] LFSR_POLY_DEFAULT   = 32'h8000_0057;
  localparam logic [31:0] LFSR_SEED_DEFAULT   = 32'h2A2A_2A2A;
  localparam int unsigned LFSR_WARMUP_DEFAULT = 4;

  typedef enum logic {LFSR_IDLE, LFSR_WARMUP} lfsr_state_e;

  // One Galois step: shift right, fold the taps in when a one falls out.
  function automatic logic [31:0] lfsr_step(input logic [31:0] val, input logic [31:0] poly);
    lfsr_step = val[0] ? ((val >> 1) ^ poly) : (val >> 1);
  endfunction

endpackage

// File: rtl/cv32e40s_lfsr_step.sv
// Pure combinational LFSR advance with zero-detect on the advanced value.
module cv32e40s_lfsr_step
  import cv32e40s_xsecure_lfsr_pkg::*;
#(
  parameter logic [31:0] POLY = LFSR_POLY_DEFAULT
) (
  input  logic [31:0] cur,
  output logic [31:0] nxt,
  output logic        zero
);

  assign nxt  = lfsr_step(cur, POLY);
  assign zero = (nxt == '0);

endmodule

// File: rtl/cv32e40s_xsecure_lfsr.sv
// Pseudo-random source for the dummy-instruction inserter, with reseed, lockup
// recovery and counter-reset pulse. Define CV32E40S_LFSR_WARMUP_EN for post-seed warm-up.
module cv32e40s_xsecure_lfsr
  import cv32e40s_xsecure_lfsr_pkg::*;
#(
  parameter logic [31:0] POLY          = LFSR_POLY_DEFAULT,
  parameter logic [31:0] DEFAULT_SEED  = LFSR_SEED_DEFAULT,
  parameter int unsigned WARMUP_SHIFTS = LFSR_WARMUP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        shift_i,
  input  logic        seed_we_i,
  input  logic [31:0] seed_wdata_i,
  input  logic        cpuctrl_we_i,
  output logic [31:0] lfsr_o,
  output logic        lfsr_valid_o,
  output logic        cntrst_o,
  output logic        lockup_o
);

  logic [31:0] lfsr_q, lfsr_n, cand, step_nxt;
  logic        step_zero, load, zero;
  logic        cntrst_q, lockup_q;

  cv32e40s_lfsr_step #(.POLY(POLY)) u_step (
    .cur  (lfsr_q),
    .nxt  (step_nxt),
    .zero (step_zero)
  );

`ifdef CV32E40S_LFSR_WARMUP_EN
  lfsr_state_e state_q, state_n;
  logic [3:0]  cnt_q, cnt_n;

  always_comb begin
    cand    = lfsr_q;
    load    = 1'b0;
    state_n = state_q;
    cnt_n   = cnt_q;
    if (seed_we_i) begin
      cand    = seed_wdata_i;
      load    = 1'b1;
      state_n = LFSR_WARMUP;
      cnt_n   = 4'(WARMUP_SHIFTS);
    end else if (state_q == LFSR_WARMUP) begin
      // shift_i is deliberately ignored while warming up
      cand  = step_nxt;
      load  = 1'b1;
      cnt_n = cnt_q - 4'd1;
      if (cnt_q == 4'd1) state_n = LFSR_IDLE;
    end else if (shift_i) begin
      cand = step_nxt;
      load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LFSR_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  assign lfsr_valid_o = (state_q == LFSR_IDLE);
`else
  logic unused_cfg;
  assign unused_cfg = (WARMUP_SHIFTS != 0);

  always_comb begin
    cand = lfsr_q;
    load = 1'b0;
    if (seed_we_i) begin
      cand = seed_wdata_i;
      load = 1'b1;
    end else if (shift_i) begin
      cand = step_nxt;
      load = 1'b1;
    end
  end

  assign lfsr_valid_o = 1'b1;
`endif

  // All-zero is a lockup state for a Galois LFSR; substitute the default seed.
  assign zero   = seed_we_i ? (seed_wdata_i == '0) : (load & step_zero);
  assign lfsr_n = zero ? DEFAULT_SEED : cand;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q   <= DEFAULT_SEED;
      cntrst_q <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_n;
      cntrst_q <= seed_we_i | cpuctrl_we_i;
      lockup_q <= zero;
    end
  end

  assign lfsr_o   = lfsr_q;
  assign cntrst_o = cntrst_q;
  assign lockup_o = lockup_q;

endmodule
